// File: rtl/freq_meter2d_pkg.sv
// Shared definitions for the two-digit frequency meter: BCD digit limits,
// FSM state encoding and the saturating two-digit BCD increment.
package freq_meter2d_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  // FSM state encoding, kept as plain constants for compatibility with
  // existing blocks that compare against these values.
  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_MEASURE = 1'b1;

  // Two BCD digits plus the sticky overflow flag.
  typedef struct packed {
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] ones;
    logic             ovf;
  } bcd2_t;

  // One step of the saturating counter: 9 rolls to 0 with a carry,
  // 99 holds and raises overflow.
  function automatic bcd2_t bcd2_inc(input bcd2_t c);
    bcd2_t n;
    n = c;
    if (c.tens == BCD_MAX && c.ones == BCD_MAX) begin
      n.ovf = 1'b1;
    end else if (c.ones == BCD_MAX) begin
      n.ones = '0;
      n.tens = c.tens + 1'b1;
    end else begin
      n.ones = c.ones + 1'b1;
    end
    return n;
  endfunction

endpackage

// File: rtl/freq_meter2d_if.sv
// Measurement-side signal bundle of the frequency meter: enable and the
// measured signal go in, the latched two-digit result comes out.
interface freq_meter2d_if;
  import freq_meter2d_pkg::*;

  logic             en;
  logic             sig_in;
  logic [BCD_W-1:0] tens;
  logic [BCD_W-1:0] ones;
  logic             ovf;
  logic             valid;

  // Controller / display side.
  modport master (
    output en,
    output sig_in,
    input  tens,
    input  ones,
    input  ovf,
    input  valid
  );

  // Meter side.
  modport slave (
    input  en,
    input  sig_in,
    output tens,
    output ones,
    output ovf,
    output valid
  );

endinterface

// File: rtl/freq_meter2d_bcd_sat_cnt2.sv
// Two-digit saturating BCD counter used as the working count of one gate
// window. Clear has priority over increment.
module bcd_sat_cnt2
  import freq_meter2d_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [BCD_W-1:0] o_tens,
  output logic [BCD_W-1:0] o_ones,
  output logic             o_ovf
);

  bcd2_t r_cnt;

  // Working count: clear, else step once per counted edge.
  // NOTE: state uses non-blocking assignments and the async reset sits in the
  // sensitivity list, so every register updates together from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= bcd2_inc(r_cnt);
    end
  end

  assign o_tens = r_cnt.tens;
  assign o_ones = r_cnt.ones;
  assign o_ovf  = r_cnt.ovf;

endmodule

// File: rtl/freq_meter2d.sv
// Two-digit frequency meter: synchronises sig_in, counts its rising edges
// over a gate window of GATE_CYCLES clocks and latches the BCD result.
module freq_meter2d
  import freq_meter2d_pkg::*;
#(
  parameter int GATE_CYCLES = 50_000_000,
  parameter int TMR_W       = 26
) (
  input  logic           clk,
  input  logic           rst,
  freq_meter2d_if.slave  bus
);

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GATE_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  logic             r_s3;
  logic [0:0]       r_state;
  logic [TMR_W-1:0] r_tmr;
  bcd2_t            r_res;
  logic             r_valid;

  logic             w_edge;
  logic             w_last;
  logic             w_inc;
  logic             w_clr;
  logic [BCD_W-1:0] w_cnt_tens;
  logic [BCD_W-1:0] w_cnt_ones;
  logic             w_cnt_ovf;
  bcd2_t            w_cnt;
  bcd2_t            w_final;

  // Synchroniser plus edge-detect stage; runs in every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= bus.sig_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_edge = r_s2 & ~r_s3;
  assign w_last = (r_state == ST_MEASURE) && (r_tmr == TMR_LAST);
  assign w_inc  = (r_state == ST_MEASURE) && w_edge;
  // The count restarts on entry to a window, at every window close and on
  // abort. An edge in the closing cycle is folded into w_final instead of
  // the counter, so the new window always starts from zero.
  assign w_clr  = (r_state == ST_IDLE) || w_last || !bus.en;

  bcd_sat_cnt2 u_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_clr),
    .i_inc  (w_inc),
    .o_tens (w_cnt_tens),
    .o_ones (w_cnt_ones),
    .o_ovf  (w_cnt_ovf)
  );

  assign w_cnt   = '{tens: w_cnt_tens, ones: w_cnt_ones, ovf: w_cnt_ovf};
  assign w_final = w_edge ? bcd2_inc(w_cnt) : w_cnt;

  // Gate FSM, window timer, result latch and the one-cycle valid pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_tmr   <= '0;
      r_res   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (bus.en) begin
          r_state <= ST_MEASURE;
          r_tmr   <= '0;
        end
      end else if (w_last) begin
        // Closing cycle wins over a simultaneous disable: result still latched.
        r_res   <= w_final;
        r_valid <= 1'b1;
        r_tmr   <= '0;
        if (!bus.en) begin
          r_state <= ST_IDLE;
        end
      end else if (!bus.en) begin
        // Abort: partial window dropped, previous result kept.
        r_state <= ST_IDLE;
        r_tmr   <= '0;
      end else begin
        r_tmr <= r_tmr + 1'b1;
      end
    end
  end

  assign bus.tens  = r_res.tens;
  assign bus.ones  = r_res.ones;
  assign bus.ovf   = r_res.ovf;
  assign bus.valid = r_valid;

endmodule

// File: tb/tb_freq_meter2d.sv
// Directed bench for freq_meter2d: a 20-cycle-gate instance for rate,
// abort, reset and boundary cases and a 256-cycle-gate instance for
// overflow and the BCD carry.
module tb_freq_meter2d;

  logic clk;
  logic rst;
  logic sig;
  int   per;
  int   ph;
  int   n_cmp;
  int   n_bad;
  int   n;
  int   nv;

  freq_meter2d_if bus_a ();
  freq_meter2d_if bus_b ();

  freq_meter2d #(.GATE_CYCLES(20), .TMR_W(5)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  freq_meter2d #(.GATE_CYCLES(256), .TMR_W(8)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive_sig(input logic v);
    sig          = v;
    bus_a.sig_in = v;
    bus_b.sig_in = v;
  endtask

  // Advance one clock; inputs change 1 time unit after the edge, outputs
  // are sampled there too. A nonzero per produces a 50% square wave.
  task automatic tick();
    @(posedge clk);
    #1;
    if (per > 0) begin
      drive_sig((ph % per) < (per / 2));
      ph++;
    end
  endtask

  // Tick until the selected instance shows valid; n is the tick count.
  task automatic wait_valid(input bit sel_b, input string tag, input int budget,
                            output int cnt);
    logic seen;
    cnt  = 0;
    seen = 1'b0;
    while (!seen && cnt < budget) begin
      tick();
      cnt++;
      seen = sel_b ? bus_b.valid : bus_a.valid;
    end
    check({tag, "_seen"}, int'(seen), 1);
  endtask

  task automatic check_a(input string tag, input int t, input int o, input int f);
    check({tag, "_tens"}, int'(bus_a.tens), t);
    check({tag, "_ones"}, int'(bus_a.ones), o);
    check({tag, "_ovf"},  int'(bus_a.ovf),  f);
  endtask

  task automatic check_b(input string tag, input int t, input int o, input int f);
    check({tag, "_tens"}, int'(bus_b.tens), t);
    check({tag, "_ones"}, int'(bus_b.ones), o);
    check({tag, "_ovf"},  int'(bus_b.ovf),  f);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    per   = 0;
    ph    = 0;
    rst   = 1'b1;
    bus_a.en = 1'b0;
    bus_b.en = 1'b0;
    drive_sig(1'b0);
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state.
    check_a("rst0", 0, 0, 0);
    check("rst0_valid", int'(bus_a.valid), 0);

    // Steady period 4: 5 edges per 20-cycle window, results 20 cycles apart.
    per = 4;
    repeat (8) tick();
    bus_a.en = 1'b1;
    tick();
    wait_valid(1'b0, "p4_w1", 40, n);
    check("p4_first_latency", n, 20);
    check_a("p4_w1", 0, 5, 0);
    tick();
    check("p4_pulse_width", int'(bus_a.valid), 0);
    wait_valid(1'b0, "p4_w2", 40, n);
    check("p4_gap2", n + 1, 20);
    check_a("p4_w2", 0, 5, 0);
    wait_valid(1'b0, "p4_w3", 40, n);
    check("p4_gap3", n, 20);
    check_a("p4_w3", 0, 5, 0);

    // Abort at cycle 10 of a window: no result, outputs hold 0/5.
    repeat (10) tick();
    bus_a.en = 1'b0;
    nv = 0;
    repeat (30) begin
      tick();
      if (bus_a.valid) nv++;
    end
    check("abort_no_valid", nv, 0);
    check_a("abort_hold", 0, 5, 0);
    bus_a.en = 1'b1;
    tick();
    wait_valid(1'b0, "abort_restart", 40, n);
    check("abort_restart_latency", n, 20);
    check_a("abort_restart", 0, 5, 0);

    // Period 2: 10 edges per window; first window after the switch is mixed.
    per = 2;
    wait_valid(1'b0, "p2_mix", 40, n);
    wait_valid(1'b0, "p2_w", 40, n);
    check("p2_gap", n, 20);
    check_a("p2_w", 1, 0, 0);

    // Asynchronous reset mid-window with en high.
    repeat (7) tick();
    rst = 1'b1;
    #1;
    check_a("rst_mid", 0, 0, 0);
    check("rst_mid_valid", int'(bus_a.valid), 0);
    tick();
    bus_a.en = 1'b0;
    rst = 1'b0;
    nv = 0;
    repeat (25) begin
      tick();
      if (bus_a.valid) nv++;
    end
    check("rst_after_no_valid", nv, 0);

    // Boundary: rise set after edge k+17 reaches the edge detector in the
    // last window cycle and belongs to the closing window.
    per = 0;
    drive_sig(1'b0);
    repeat (5) tick();
    bus_a.en = 1'b1;
    tick();
    repeat (17) tick();
    drive_sig(1'b1);
    wait_valid(1'b0, "bnd_in", 10, n);
    check("bnd_in_latency", n, 3);
    check_a("bnd_in", 0, 1, 0);

    // Same rise one cycle later lands in the first cycle of the next window.
    bus_a.en = 1'b0;
    tick();
    drive_sig(1'b0);
    repeat (5) tick();
    bus_a.en = 1'b1;
    tick();
    repeat (18) tick();
    drive_sig(1'b1);
    wait_valid(1'b0, "bnd_shift_w1", 10, n);
    check_a("bnd_shift_w1", 0, 0, 0);
    wait_valid(1'b0, "bnd_shift_w2", 40, n);
    check("bnd_shift_gap", n, 20);
    check_a("bnd_shift_w2", 0, 1, 0);
    bus_a.en = 1'b0;

    // Overflow: 128 edges in a 256-cycle window saturate at 99.
    per = 2;
    repeat (4) tick();
    bus_b.en = 1'b1;
    tick();
    wait_valid(1'b1, "ovf_w1", 300, n);
    check("ovf_latency", n, 256);
    check_b("ovf_w1", 9, 9, 1);

    // Period 4: 64 edges, overflow cleared (one mixed window skipped).
    per = 4;
    wait_valid(1'b1, "p4b_mix", 300, n);
    wait_valid(1'b1, "p4b_w", 300, n);
    check("p4b_gap", n, 256);
    check_b("p4b_w", 6, 4, 0);

    // BCD carry: 12 bench-driven edges in one window give 12.
    per = 0;
    drive_sig(1'b0);
    wait_valid(1'b1, "c12_sync", 300, n);
    for (int i = 0; i < 12; i++) begin
      drive_sig(1'b1);
      tick();
      drive_sig(1'b0);
      tick();
    end
    wait_valid(1'b1, "c12_w", 300, n);
    check_b("c12_w", 1, 2, 0);
    bus_b.en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
